// File: rtl/cpu_alu_datapath_mc_if.sv
// Op/result bus between the decoder/controller and the ALU datapath.
// The controller drives the op side; the datapath returns result, W and flags.
interface cpu_alu_datapath_mc_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) ();
  logic                      op_valid;
  logic                      op_ready;
  logic [3:0]                op_code;
  logic                      dest_w;
  logic [SEL_W-1:0]          src_sel;
  logic [NUM_SRC*DATA_W-1:0] src_bus;
  logic                      carry_in;
  logic [DATA_W-1:0]         alu_out;
  logic [DATA_W-1:0]         prod_hi;
  logic [DATA_W-1:0]         w_out;
  logic                      result_valid;
  logic [2:0]                status_out;
  logic                      c_load;
  logic                      dc_load;
  logic                      z_load;

  modport master (
    output op_valid, op_code, dest_w, src_sel, src_bus, carry_in,
    input  op_ready, alu_out, prod_hi, w_out, result_valid, status_out,
           c_load, dc_load, z_load
  );

  modport slave (
    input  op_valid, op_code, dest_w, src_sel, src_bus, carry_in,
    output op_ready, alu_out, prod_hi, w_out, result_valid, status_out,
           c_load, dc_load, z_load
  );
endinterface

// File: rtl/cpu_alu_datapath_mc.sv
// Handshaked ALU/W datapath: single-cycle ALU ops plus a DATA_W-step
// shift-add multiplier. status is {Z,DC,C}.
module cpu_alu_datapath_mc #(
  parameter int DATA_W  = 8,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input logic                  clk,
  input logic                  rst,
  cpu_alu_datapath_mc_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W:0]  ONE_X    = (DATA_W + 1)'(1);
  localparam int H = DATA_W / 2;

  typedef enum logic {IDLE, MUL_RUN} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0]   w_q, w_d, alu_out_q, alu_out_d, prod_hi_q, prod_hi_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          status_q, status_d;
  logic rv_q, rv_d, c_ld_q, c_ld_d, dc_ld_q, dc_ld_d, z_ld_q, z_ld_d;
  logic dest_q, dest_d;

  logic [NUM_SRC-1:0][DATA_W-1:0] srcs;
  logic [DATA_W-1:0]              s;
  assign srcs = bus.src_bus;

  // Out-of-range selects fall back to source 0.
  always_comb begin
    s = srcs[0];
    for (int i = 1; i < NUM_SRC; i++)
      if (bus.src_sel == i[SEL_W-1:0]) s = srcs[i];
  end

  // One shift-add step: add multiplicand into the high half, shift right.
  logic [DATA_W:0]     msum;
  logic [2*DATA_W-1:0] mul_nx;
  assign msum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]} +
                  (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_nx = {msum, prod_q[DATA_W-1:1]};

  always_comb begin
    logic [DATA_W:0]   ext;
    logic [4:0]        nib;
    logic [DATA_W-1:0] r;
    state_d   = state_q;
    w_d       = w_q;
    alu_out_d = alu_out_q;
    prod_hi_d = prod_hi_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    dest_d    = dest_q;
    rv_d      = 1'b0;
    c_ld_d    = 1'b0;
    dc_ld_d   = 1'b0;
    z_ld_d    = 1'b0;
    ext       = '0;
    nib       = '0;
    r         = w_q;
    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          if (bus.op_code == 4'd14) begin
            state_d = MUL_RUN;
            mcand_d = w_q;
            prod_d  = {{DATA_W{1'b0}}, s};
            cnt_d   = CNT_INIT;
            dest_d  = bus.dest_w;
          end else begin
            rv_d = 1'b1;
            case (bus.op_code)
              4'd0: begin
                ext = {1'b0, w_q} + {1'b0, s};
                nib = {1'b0, w_q[3:0]} + {1'b0, s[3:0]};
                r = ext[DATA_W-1:0];
                status_d[1:0] = {nib[4], ext[DATA_W]};
                {c_ld_d, dc_ld_d, z_ld_d} = 3'b111;
              end
              4'd1: begin
                // S - W as S + ~W + 1: carry out is the active-high no-borrow.
                ext = {1'b0, s} + {1'b0, ~w_q} + ONE_X;
                nib = {1'b0, s[3:0]} + {1'b0, ~w_q[3:0]} + 5'd1;
                r = ext[DATA_W-1:0];
                status_d[1:0] = {nib[4], ext[DATA_W]};
                {c_ld_d, dc_ld_d, z_ld_d} = 3'b111;
              end
              4'd2:  begin r = w_q & s;  z_ld_d = 1'b1; end
              4'd3:  begin r = w_q | s;  z_ld_d = 1'b1; end
              4'd4:  begin r = w_q ^ s;  z_ld_d = 1'b1; end
              4'd5:  begin r = ~s;       z_ld_d = 1'b1; end
              4'd6:  begin r = s + 1'b1; z_ld_d = 1'b1; end
              4'd7:  begin r = s - 1'b1; z_ld_d = 1'b1; end
              4'd8: begin
                r = {s[DATA_W-2:0], bus.carry_in};
                status_d[0] = s[DATA_W-1];
                c_ld_d = 1'b1;
              end
              4'd9: begin
                r = {bus.carry_in, s[DATA_W-1:1]};
                status_d[0] = s[0];
                c_ld_d = 1'b1;
              end
              4'd10: r = {s[H-1:0], s[DATA_W-1:H]};
              4'd11: begin r = s;  z_ld_d = 1'b1; end
              4'd13: begin r = '0; z_ld_d = 1'b1; end
              default: r = w_q;
            endcase
            if (z_ld_d) status_d[2] = (r == '0);
            alu_out_d = r;
            if (bus.dest_w) w_d = r;
          end
        end
      end
      MUL_RUN: begin
        prod_d = mul_nx;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d     = IDLE;
          alu_out_d   = mul_nx[DATA_W-1:0];
          prod_hi_d   = mul_nx[2*DATA_W-1:DATA_W];
          status_d[2] = (mul_nx == '0);
          status_d[0] = (mul_nx[2*DATA_W-1:DATA_W] != '0);
          rv_d   = 1'b1;
          c_ld_d = 1'b1;
          z_ld_d = 1'b1;
          if (dest_q) w_d = mul_nx[DATA_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_q <= '0; alu_out_q <= '0; prod_hi_q <= '0; mcand_q <= '0;
      prod_q <= '0; cnt_q <= '0; status_q <= '0; dest_q <= 1'b0;
      rv_q <= 1'b0; c_ld_q <= 1'b0; dc_ld_q <= 1'b0; z_ld_q <= 1'b0;
    end else begin
      w_q <= w_d; alu_out_q <= alu_out_d; prod_hi_q <= prod_hi_d;
      mcand_q <= mcand_d; prod_q <= prod_d; cnt_q <= cnt_d;
      status_q <= status_d; dest_q <= dest_d;
      rv_q <= rv_d; c_ld_q <= c_ld_d; dc_ld_q <= dc_ld_d; z_ld_q <= z_ld_d;
    end
  end

  assign bus.op_ready     = (state_q == IDLE);
  assign bus.alu_out      = alu_out_q;
  assign bus.prod_hi      = prod_hi_q;
  assign bus.w_out        = w_q;
  assign bus.result_valid = rv_q;
  assign bus.status_out   = status_q;
  assign bus.c_load       = c_ld_q;
  assign bus.dc_load      = dc_ld_q;
  assign bus.z_load       = z_ld_q;
endmodule

// File: doc/cpu_alu_datapath_mc.md
Name: cpu_alu_datapath_mc

Overview:
Parametrised, handshaked ALU datapath for the PIC10-compatible core, and the successor to the single-cycle ALU/W datapath.
- Generalises data width and the number of operand sources.
- Adds an explicit op/result handshake.
- Adds a multi-cycle shift-add multiplier with a high-product register.
- Sits between the decoder/controller FSM and the register file/status register. It owns the W accumulator.

Parameters:
DATA_W, 8, datapath width; must be even and ≥8.
NUM_SRC, 4, number of operand sources on src_bus; must be ≥2.
SEL_W, 2, width of src_sel; must satisfy 2^SEL_W ≥ NUM_SRC.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
op_valid  in  1  operation request
op_ready  out  1  block can accept an op this cycle
op_code  in  4  operation select (see Behaviour)
dest_w  in  1  1 = write result to W on completion
src_sel  in  SEL_W  operand source select
src_bus  in  NUM_SRC*DATA_W  packed sources; source i = bits [i*DATA_W +: DATA_W]
carry_in  in  1  current STATUS.C
alu_out  out  DATA_W  registered result (low half for MUL)
prod_hi  out  DATA_W  registered high half of last MUL
w_out  out  DATA_W  W accumulator contents
result_valid  out  1  one-cycle pulse: alu_out/flags valid
status_out  out  3  {Z,DC,C} of last result
c_load  out  1  pulse with result_valid when the op affects C
dc_load  out  1  pulse with result_valid when the op affects DC
z_load  out  1  pulse with result_valid when the op affects Z

Behaviour:
- Reset: rst low at a rising edge resets everything, including mid-MUL. After that edge: state IDLE, W=0, alu_out=0, prod_hi=0, status_out=0, all pulses 0, op_ready=1. Any op in flight is discarded.
- Operand: S = source src_sel, or source 0 if src_sel ≥ NUM_SRC. S and W are sampled at the accept edge.
- Accept: op_valid && op_ready at a rising edge. op_valid while op_ready=0 is ignored, not queued.
- FSM has two states, IDLE and MUL_RUN. op_ready=1 only in IDLE.
- Single-cycle ops (IDLE→IDLE): result is registered at the accept edge, and result_valid plus load strobes are high for the following cycle. Back-to-back ops are accepted every cycle.
- MUL (op 14): the accept edge loads the operands and a counter set to DATA_W-1, and moves to MUL_RUN. Each edge performs one shift-add step.
  - On the edge where counter=0, the block writes the result and returns to IDLE.
  - result_valid is high in the cycle after edge k+DATA_W, where k is the accept edge; op_ready is low for DATA_W cycles.
- W is written on the completion edge iff dest_w (latched at accept) is 1.
- Ops; flags affected are in brackets, r = result:
  - 0 ADD, r=W+S [C,DC,Z]
  - 1 SUB, r=S-W [C,DC,Z]; C=1 means no borrow, DC=1 means no borrow out of bit 3
  - 2 AND [Z]
  - 3 IOR [Z]
  - 4 XOR [Z]
  - 5 COM, r=~S [Z]
  - 6 INC, r=S+1 [Z]
  - 7 DEC, r=S-1 [Z]
  - 8 RLF, r={S[DATA_W-2:0],carry_in} [C=S[MSB]]
  - 9 RRF, r={carry_in,S[DATA_W-1:1]} [C=S[0]]
  - 10 SWAP, exchanges the upper and lower halves of S [none]
  - 11 MOVF, r=S [Z]
  - 12 MOVW, r=W [none]
  - 13 CLR, r=0 [Z=1]
  - 14 MUL, {prod_hi,alu_out}=W*S unsigned [Z: full 2·DATA_W product is zero; C=(prod_hi≠0)]
  - 15 reserved, behaves as MOVW
- Flag semantics:
  - DC is the carry out of bit 3 for all widths.
  - Flags not affected keep their previous status_out value, and their load strobe stays 0.
  - prod_hi changes only on MUL completion.
- Arithmetic wraps modulo 2^DATA_W: INC of all-ones gives 0 with Z=1; DEC of 0 gives all-ones.
- result_valid, c_load, dc_load and z_load are never high for more than one consecutive cycle per op.

Test Plan:
- DATA_W=8, NUM_SRC=4, W=0x0F (loaded via MOVF dest_w=1), ADD src=0x01 → next cycle result_valid=1, alu_out=0x10, status {Z,DC,C}=010, all three loads high, and W=0x10 if dest_w=1.
- SUB with W=0x05, S=0x05 → alu_out=0x00, status=111; then SUB S=0x04 → alu_out=0xFF, C=0, DC=0, Z=0.
- MUL W=0x12, S=0x34 → op_ready low 8 cycles, result_valid on the 8th cycle after accept, alu_out=0xA8, prod_hi=0x03, C=1, Z=0. op_valid held high during the run is not accepted until op_ready returns.
- RLF src=0x80 with carry_in=1 → alu_out=0x01, C=1, c_load=1, z_load=0. Then SWAP src=0xA5 → 0x5A with no load strobes.
- rst low at cycle 3 of a MUL → next cycle op_ready=1, W=0, alu_out=0, prod_hi=0, status_out=0, and no result_valid pulse.
- NUM_SRC=3, src_sel=3 → source 0 is used. Back-to-back ADD/XOR/INC over three consecutive cycles → three consecutive result_valid pulses with correct values.
